// File: rtl/c880_sig_analyzer.sv
// c880_sig_analyzer
//   Built-in self-test harness for one combinational c880 instance. A 60-bit
//   LFSR drives the c880 primary inputs. The 26 primary outputs are folded
//   into a MISR signature, one pattern at a time. At the end of a run the
//   signature is compared with a golden value, giving a sticky pass/fail
//   verdict. A tampered netlist produces a divergent signature.
//
//   Ports:
//     clk           rising-edge clock
//     rst           synchronous active-high reset
//     start         begin a run (sampled only while idle)
//     abort         terminate a run and return to idle
//     stim_out      stimulus to the c880 inputs (N1..N268)
//     resp_in       c880 outputs (N388..N880)
//     busy          high while a run is in progress
//     done          one-cycle pulse when a run completes
//     pass / fail   sticky verdict of the last completed run
//     signature     current MISR value (0 until the first LOAD)
//     pattern_count patterns captured in the current or last run
module c880_sig_analyzer #(
  parameter int                 PAT_W         = 60,
  parameter int                 RSP_W         = 26,
  parameter int                 NUM_PATTERNS  = 1024,
  parameter int                 SETTLE_CYCLES = 2,
  parameter logic [PAT_W-1:0]   LFSR_SEED     = 60'h1,
  parameter logic [RSP_W-1:0]   MISR_SEED     = 26'h0,
  parameter logic [RSP_W-1:0]   GOLDEN_SIG    = 26'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [PAT_W-1:0] stim_out,
  input  logic [RSP_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [RSP_W-1:0] signature,
  output logic [15:0]      pattern_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_APPLY   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [PAT_W-1:0] LFSR_INIT =
    (LFSR_SEED == '0) ? {{(PAT_W-1){1'b0}}, 1'b1} : LFSR_SEED;
  // x^26 + x^6 + x^2 + x + 1 (the x^26 term is the bit shifted out)
  localparam logic [RSP_W-1:0] MISR_POLY   = 26'h0000047;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      PAT_LAST    = 16'(NUM_PATTERNS - 1);

  logic [2:0]       r_state;
  logic [PAT_W-1:0] r_lfsr;
  logic [RSP_W-1:0] r_misr;
  logic [3:0]       r_settle;
  logic [15:0]      r_pat_cnt;
  logic [PAT_W-1:0] r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_sig_en;

  logic [2:0]       w_state_next;
  logic [PAT_W-1:0] w_lfsr_next;
  logic [RSP_W-1:0] w_misr_next;

  assign w_lfsr_next = {r_lfsr[PAT_W-2:0], r_lfsr[PAT_W-1] ^ r_lfsr[PAT_W-2]};
  assign w_misr_next = ({r_misr[RSP_W-2:0], 1'b0} ^
                        (r_misr[RSP_W-1] ? MISR_POLY : {RSP_W{1'b0}})) ^ resp_in;

  // Next-state decode; abort outranks every in-run transition.
  always_comb begin
    w_state_next = r_state;
    if (abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            w_state_next = S_LOAD;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_LOAD: begin
          w_state_next = S_APPLY;
        end
        S_APPLY: begin
          if (r_settle == SETTLE_LAST) begin
            w_state_next = S_CAPTURE;
          end else begin
            w_state_next = S_APPLY;
          end
        end
        S_CAPTURE: begin
          if (r_pat_cnt == PAT_LAST) begin
            w_state_next = S_COMPARE;
          end else begin
            w_state_next = S_APPLY;
          end
        end
        S_COMPARE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // State, LFSR/MISR datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lfsr    <= LFSR_INIT;
      r_misr    <= MISR_SEED;
      r_settle  <= 4'd0;
      r_pat_cnt <= 16'd0;
      r_stim    <= {PAT_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_sig_en  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= 1'b0;
      if (abort && (r_state != S_IDLE)) begin
        // Signature and pattern count are left holding for inspection.
        r_pass <= 1'b0;
        r_fail <= 1'b0;
        r_stim <= {PAT_W{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: begin
            r_stim <= {PAT_W{1'b0}};
          end
          S_LOAD: begin
            r_lfsr    <= LFSR_INIT;
            r_misr    <= MISR_SEED;
            r_pat_cnt <= 16'd0;
            r_settle  <= 4'd0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_sig_en  <= 1'b1;
            // The stimulus port mirrors the LFSR from the first APPLY cycle.
            r_stim    <= LFSR_INIT;
          end
          S_APPLY: begin
            r_settle <= r_settle + 4'd1;
            r_stim   <= r_lfsr;
          end
          S_CAPTURE: begin
            r_misr    <= w_misr_next;
            r_lfsr    <= w_lfsr_next;
            r_pat_cnt <= r_pat_cnt + 16'd1;
            r_settle  <= 4'd0;
            if (w_state_next == S_APPLY) begin
              r_stim <= w_lfsr_next;
            end else begin
              r_stim <= {PAT_W{1'b0}};
            end
          end
          S_COMPARE: begin
            r_pass <= (r_misr == GOLDEN_SIG);
            r_fail <= (r_misr != GOLDEN_SIG);
            r_done <= 1'b1;
            r_stim <= {PAT_W{1'b0}};
          end
          default: begin
            r_stim <= {PAT_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign stim_out      = r_stim;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail          = r_fail;
  // The MISR reset value stays hidden until a run has loaded it.
  assign signature     = r_sig_en ? r_misr : {RSP_W{1'b0}};
  assign pattern_count = r_pat_cnt;

endmodule

// File: tb/tb_c880_sig_analyzer.sv
// Testbench for c880_sig_analyzer. Five instances with different parameter
// sets share clock and reset. Each instance sees either a zero response
// (a stand-in for a clean c880 whose outputs stay low) or a loopback of
// stim_out[25:0]. Expected stimulus per pattern goes into a queue before each
// run and is popped as every capture is observed.
module tb_c880_sig_analyzer;

  localparam int NI = 5;
  localparam int          P_NUM  [NI] = '{4, 1, 2, 64, 1024};
  localparam int          P_SET  [NI] = '{1, 1, 1, 3, 2};
  localparam logic [59:0] P_LS   [NI] = '{60'h1, 60'h1, 60'h1, 60'h0, 60'h1};
  localparam logic [25:0] P_MS   [NI] = '{26'h0, 26'h0, 26'h0, 26'h155, 26'h0};
  localparam logic [25:0] P_GS   [NI] = '{26'h0, 26'h1, 26'h0, 26'h3ffffff, 26'h0};
  localparam bit          P_LOOP [NI] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        start [NI];
  logic        abort [NI];
  logic [25:0] fault [NI];
  logic [59:0] stim  [NI];
  logic [25:0] resp  [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        pass  [NI];
  logic        fail  [NI];
  logic [25:0] sig   [NI];
  logic [15:0] pc    [NI];

  int total = 0;
  int bad   = 0;
  logic [59:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign resp[g] = (P_LOOP[g] ? stim[g][25:0] : 26'h0) ^ fault[g];
    c880_sig_analyzer #(
      .NUM_PATTERNS (P_NUM[g]),
      .SETTLE_CYCLES(P_SET[g]),
      .LFSR_SEED    (P_LS[g]),
      .MISR_SEED    (P_MS[g]),
      .GOLDEN_SIG   (P_GS[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start[g]),
      .abort        (abort[g]),
      .stim_out     (stim[g]),
      .resp_in      (resp[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .pass         (pass[g]),
      .fail         (fail[g]),
      .signature    (sig[g]),
      .pattern_count(pc[g])
    );
  end

  function automatic logic [59:0] lfsr_step(input logic [59:0] l);
    return {l[58:0], l[59] ^ l[58]};
  endfunction

  function automatic logic [25:0] misr_step(input logic [25:0] m, input logic [25:0] r);
    return ({m[24:0], 1'b0} ^ (m[25] ? 26'h0000047 : 26'h0)) ^ r;
  endfunction

  // One run on instance i. fault_k flips resp bit 3 for pattern fault_k,
  // abort_k raises abort once pattern_count reaches abort_k, and xstart_edge
  // pulses start again at that edge while the run is busy (-1 = unused).
  task automatic run_scored(input int i, input int fault_k, input int abort_k,
                            input int xstart_edge);
    logic [59:0] l, e, stim_prev;
    logic [25:0] m, m_abort, r;
    logic [15:0] pc_prev;
    int n, limit, edges, done_edge;
    bit aborted, late_done;
    n = P_NUM[i];
    l = (P_LS[i] == 60'h0) ? 60'h1 : P_LS[i];
    m = P_MS[i];
    m_abort = m;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(l);
      if (k == abort_k) m_abort = m;
      r = (P_LOOP[i] ? l[25:0] : 26'h0) ^ ((k == fault_k) ? 26'h8 : 26'h0);
      m = misr_step(m, r);
      l = lfsr_step(l);
    end
    @(negedge clk);
    start[i] = 1'b1;
    limit = n * (P_SET[i] + 1) + 10;
    edges = 0; done_edge = 0; aborted = 1'b0;
    pc_prev = 16'd0; stim_prev = 60'h0;
    while (edges < limit && done_edge == 0 && !aborted) begin
      @(posedge clk); #1;
      edges++;
      start[i] = (edges == xstart_edge);
      if (edges == 1) begin
        total++;
        if (busy[i] !== 1'b1) begin
          bad++; $display("FAIL busy_after_start inst=%0d got=%b exp=1", i, busy[i]);
        end
      end else if (abort[i]) begin
        abort[i] = 1'b0;
        aborted = 1'b1;
      end else begin
        if (edges == 2) begin
          pc_prev = pc[i];
          total++;
          if (pc[i] !== 16'd0 || sig[i] !== P_MS[i]) begin
            bad++; $display("FAIL load_state inst=%0d got pc=%0d sig=%h exp pc=0 sig=%h",
                            i, pc[i], sig[i], P_MS[i]);
          end
        end else if (pc[i] !== pc_prev) begin
          pc_prev = pc[i];
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL extra_capture inst=%0d got pc=%0d exp=%0d", i, pc[i], n);
          end else begin
            e = exp_q.pop_front();
            if (stim_prev !== e) begin
              bad++; $display("FAIL stim inst=%0d pat=%0d got=%h exp=%h", i, pc[i], stim_prev, e);
            end
          end
        end
        fault[i] = (int'(pc[i]) == fault_k) ? 26'h8 : 26'h0;
        if (int'(pc[i]) == abort_k) abort[i] = 1'b1;
        if (done[i]) done_edge = edges;
        stim_prev = stim[i];
      end
    end
    start[i] = 1'b0;
    fault[i] = 26'h0;
    total++;
    if (aborted) begin
      if (busy[i] !== 1'b0 || stim[i] !== 60'h0 || pass[i] !== 1'b0 || fail[i] !== 1'b0 ||
          done[i] !== 1'b0 || sig[i] !== m_abort || pc[i] !== abort_k[15:0]) begin
        bad++; $display("FAIL abort_state inst=%0d got b=%b s=%h p=%b f=%b d=%b sig=%h pc=%0d exp sig=%h pc=%0d",
                        i, busy[i], stim[i], pass[i], fail[i], done[i], sig[i], pc[i], m_abort, abort_k);
      end
      late_done = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        if (done[i] || busy[i]) late_done = 1'b1;
      end
      total++;
      if (late_done) begin
        bad++; $display("FAIL abort_no_done inst=%0d got done/busy=1 exp=0", i);
      end
    end else begin
      if (done_edge != n * (P_SET[i] + 1) + 3) begin
        bad++; $display("FAIL done_edge inst=%0d got=%0d exp=%0d", i, done_edge, n * (P_SET[i] + 1) + 3);
      end
      total++;
      if (sig[i] !== m || pass[i] !== (m == P_GS[i]) || fail[i] !== (m != P_GS[i]) ||
          pc[i] !== n[15:0] || busy[i] !== 1'b0 || exp_q.size() != 0) begin
        bad++; $display("FAIL verdict inst=%0d got sig=%h p=%b f=%b pc=%0d b=%b q=%0d exp sig=%h p=%b",
                        i, sig[i], pass[i], fail[i], pc[i], busy[i], exp_q.size(), m, (m == P_GS[i]));
      end
      @(posedge clk); #1;
      total++;
      if (done[i] !== 1'b0 || stim[i] !== 60'h0 || sig[i] !== m || pass[i] !== (m == P_GS[i])) begin
        bad++; $display("FAIL after_done inst=%0d got d=%b stim=%h sig=%h p=%b", i, done[i], stim[i], sig[i], pass[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < NI; i++) start[i] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
      end
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        total++;
        if ({busy[i], done[i], pass[i], fail[i], sig[i], pc[i], stim[i]} !== 106'h0) begin
          bad++; $display("FAIL reset inst=%0d cyc=%0d got b=%b d=%b p=%b f=%b sig=%h pc=%0d stim=%h exp all 0",
                          i, c, busy[i], done[i], pass[i], fail[i], sig[i], pc[i], stim[i]);
        end
      end
    end
  endtask

  task automatic test_zero_run();
    run_scored(0, -1, -1, -1);
  endtask

  task automatic test_loopback();
    run_scored(1, -1, -1, -1);
    total++;
    if (sig[1] !== 26'h1 || pass[1] !== 1'b1) begin
      bad++; $display("FAIL loop1_sig got=%h pass=%b exp=0000001 pass=1", sig[1], pass[1]);
    end
    run_scored(2, -1, -1, -1);
    total++;
    if (sig[2] !== 26'h0 || pass[2] !== 1'b1) begin
      bad++; $display("FAIL loop2_sig got=%h pass=%b exp=0000000 pass=1", sig[2], pass[2]);
    end
    run_scored(3, -1, -1, -1);
  endtask

  task automatic test_fault();
    run_scored(4, 10, -1, -1);
    total++;
    if (fail[4] !== 1'b1 || pass[4] !== 1'b0) begin
      bad++; $display("FAIL fault_verdict got pass=%b fail=%b exp pass=0 fail=1", pass[4], fail[4]);
    end
  endtask

  task automatic test_abort();
    run_scored(4, -1, 100, -1);
    run_scored(3, -1, 20, -1);
    run_scored(4, -1, -1, -1);
    total++;
    if (pass[4] !== 1'b1 || sig[4] !== 26'h0) begin
      bad++; $display("FAIL restart_clean got pass=%b sig=%h exp pass=1 sig=0", pass[4], sig[4]);
    end
  endtask

  task automatic test_handshake();
    run_scored(0, -1, -1, 5);
    @(negedge clk);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start[0] = 1'b0;
      abort[0] = 1'b0;
      total++;
      if (busy[0] !== 1'b0 || stim[0] !== 60'h0 || pc[0] !== 16'd4) begin
        bad++; $display("FAIL start_abort_idle cyc=%0d got busy=%b stim=%h pc=%0d exp 0/0/4", c, busy[0], stim[0], pc[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    start[3] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      start[3] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy[3], done[3], pass[3], fail[3], sig[3], pc[3], stim[3]} !== 106'h0) begin
      bad++; $display("FAIL reset_midrun got b=%b sig=%h pc=%0d stim=%h exp all 0", busy[3], sig[3], pc[3], stim[3]);
    end
    run_scored(3, -1, -1, -1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      abort[i] = 1'b0;
      fault[i] = 26'h0;
    end
    test_reset();
    test_zero_run();
    test_loopback();
    test_fault();
    test_abort();
    test_handshake();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
